// File: rtl/alu16_seq_pkg.sv
// alu16_seq shared definitions.
// Opcodes and FSM state encoding.
package alu16_seq_pkg;

  localparam logic [1:0] OP_ANDN = 2'b00;
  localparam logic [1:0] OP_NOT  = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic is_arith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu16_seq_alu8.sv
// ALU8Bit: combinational 8-bit slice.
// Ports: s opcode, a/b operands, ci carry-in; f result, co carry-out.
module ALU8Bit
  import alu16_seq_pkg::*;
(
  input  logic [1:0] s,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] f,
  output logic       co
);

  always_comb begin
    f  = '0;
    co = 1'b0;
    unique case (s)
      OP_ANDN: f = a & ~b;
      OP_NOT:  f = ~a;
      OP_INC:  {co, f} = {1'b0, a} + 9'd1;
      OP_ADD:  {co, f} = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu16_seq.sv
// alu16_seq: 16-bit ALU built from one 8-bit slice over 2 cycles.
// Ports: CLK, RST, START, S, A, B, CI in; BUSY, DONE, F, CO out.
module alu16_seq
  import alu16_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  S,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] F,
  output logic        CO
);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  s_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        ci_q;
  logic [7:0]  lo_f;
  logic        lo_c;
  logic        accept;

  logic [1:0]  alu_s;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_ci;
  logic [7:0]  alu_f;
  logic        alu_co;

  assign accept = START &&
    (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (START) state_nx = ST_LO;
      ST_LO:   state_nx = ST_HI;
      ST_HI:   state_nx = ST_DONE;
      ST_DONE: state_nx = START ? ST_LO : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // High byte of an increment is an add of zero with the low carry.
  always_comb begin
    alu_s  = s_q;
    alu_a  = a_q[7:0];
    alu_b  = b_q[7:0];
    alu_ci = ci_q;
    if (state == ST_HI) begin
      alu_a  = a_q[15:8];
      alu_b  = b_q[15:8];
      alu_ci = lo_c;
      if (s_q == OP_INC) begin
        alu_s = OP_ADD;
        alu_b = 8'h00;
      end
    end
  end

  ALU8Bit u_alu (
    .s  (alu_s),
    .a  (alu_a),
    .b  (alu_b),
    .ci (alu_ci),
    .f  (alu_f),
    .co (alu_co)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      ci_q <= 1'b0;
    end else if (accept) begin
      s_q  <= S;
      a_q  <= A;
      b_q  <= B;
      ci_q <= CI;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lo_f <= '0;
      lo_c <= 1'b0;
    end else if (state == ST_LO) begin
      lo_f <= alu_f;
      lo_c <= is_arith(s_q) & alu_co;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      F  <= '0;
      CO <= 1'b0;
    end else if (state == ST_HI) begin
      F  <= {alu_f, lo_f};
      CO <= is_arith(s_q) & alu_co;
    end
  end

  assign BUSY = (state == ST_LO) || (state == ST_HI);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_alu16_seq.sv
// Scoreboard bench for alu16_seq.
// Driver pushes expected results; monitor checks on DONE.
module tb_alu16_seq;
  import alu16_seq_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [1:0]  S = '0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        CI = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic [15:0] F;
  logic        CO;

  int checks = 0;
  int fails  = 0;
  logic [16:0] exp_q[$];
  logic prev_done = 1'b0;

  alu16_seq dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .S     (S),
    .A     (A),
    .B     (B),
    .CI    (CI),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .F     (F),
    .CO    (CO)
  );

  always #5 CLK = ~CLK;

  function automatic void check(
    input string name,
    input logic [16:0] act,
    input logic [16:0] exp
  );
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h",
        name, act, exp);
    end
  endfunction

  // Monitor: every DONE pulse must match the oldest pending result.
  always @(negedge CLK) begin
    if (!RST) begin
      if (DONE) begin
        check("done_not_consecutive",
          {16'd0, prev_done}, 17'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 17'd1, 17'd0);
        end else begin
          check("result_f_co", {F, CO}, exp_q.pop_front());
        end
      end
      prev_done = DONE;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(
    input logic [1:0]  s,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        ci,
    input logic [15:0] ef,
    input logic        eco
  );
    START = 1'b1;
    S = s; A = a; B = b; CI = ci;
    exp_q.push_back({ef, eco});
    tick();
    START = 1'b0;
    A = 16'hDEAD; B = 16'hBEEF; CI = ~ci;
    check("lo_busy_done", {15'd0, BUSY, DONE}, 17'b10);
    tick();
    check("hi_busy_done", {15'd0, BUSY, DONE}, 17'b10);
    tick();
    check("done_busy_done", {15'd0, BUSY, DONE}, 17'b01);
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) tick();
    check("reset_f_co", {F, CO}, 17'd0);
    check("reset_busy_done", {15'd0, BUSY, DONE}, 17'd0);
    RST = 1'b0;
    tick();

    run_op(OP_ADD,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    tick();
    check("idle_after_done", {15'd0, BUSY, DONE}, 17'd0);
    check("f_holds", {F, CO}, {16'h0100, 1'b0});
    run_op(OP_ADD,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op(OP_INC,  16'h12FF, 16'h0000, 1'b0, 16'h1300, 1'b0);
    run_op(OP_ANDN, 16'hF0F0, 16'hFF00, 1'b0, 16'h00F0, 1'b0);
    run_op(OP_NOT,  16'h1234, 16'h0000, 1'b0, 16'hEDCB, 1'b0);
    run_op(OP_INC,  16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1);
    run_op(OP_ADD,  16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    run_op(OP_ADD,  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    run_op(OP_ADD,  16'h0080, 16'h0080, 1'b0, 16'h0100, 1'b0);
    tick();
    tick();

    // START re-pulsed in LO with new operands is ignored.
    START = 1'b1;
    S = OP_ADD; A = 16'h0001; B = 16'h0002; CI = 1'b0;
    exp_q.push_back({16'h0003, 1'b0});
    tick();
    A = 16'h5555; B = 16'h5555;
    tick();
    START = 1'b0;
    tick();
    check("repulse_done", {16'd0, DONE}, 17'd1);
    tick();
    check("repulse_idle", {15'd0, BUSY, DONE}, 17'd0);
    tick();

    // START held through DONE: second op starts with no gap.
    START = 1'b1;
    S = OP_ADD; A = 16'h0010; B = 16'h0020; CI = 1'b0;
    exp_q.push_back({16'h0030, 1'b0});
    tick();
    A = 16'h5555;
    tick();
    tick();
    check("b2b_first_done", {16'd0, DONE}, 17'd1);
    S = OP_ANDN; A = 16'hFFFF; B = 16'h0F0F;
    exp_q.push_back({16'hF0F0, 1'b0});
    tick();
    check("b2b_no_idle", {15'd0, BUSY, DONE}, 17'b10);
    START = 1'b0;
    tick();
    tick();
    check("b2b_second_done", {16'd0, DONE}, 17'd1);
    tick();

    // Reset during HI aborts the operation.
    START = 1'b1;
    S = OP_ADD; A = 16'h1111; B = 16'h2222; CI = 1'b0;
    tick();
    START = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_f_co", {F, CO}, 17'd0);
    check("abort_busy_done", {15'd0, BUSY, DONE}, 17'd0);
    repeat (4) tick();
    check("abort_no_done", {16'd0, DONE}, 17'd0);

    // Reset wins over START at the same edge.
    RST = 1'b1;
    START = 1'b1;
    tick();
    RST = 1'b0;
    START = 1'b0;
    check("rst_priority", {15'd0, BUSY, DONE}, 17'd0);
    repeat (4) tick();

    check("scoreboard_empty", 17'(exp_q.size()), 17'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
